// File: rtl/frame_receiver_with_sync_check.sv
// Sync-tagged word receiver: hunts for SOF, assembles FRAME_BYTES bytes into a
// holding register with valid/ack handshake, flow-control back-pressure and error reporting.
module frame_receiver_with_sync_check #(
    parameter int FRAME_BYTES = 16,
    parameter int DATA_W      = 8,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W+1:0]             in_word,
    input  logic                          in_valid,
    output logic [FRAME_BYTES*DATA_W-1:0] frame_data_out,
    output logic                          frame_valid,
    input  logic                          frame_ack,
    output logic                          flow_ctrl_req,
    output logic                          sync_error,
    output logic                          overflow_err,
    output logic [CNT_W-1:0]              frame_count,
    output logic [7:0]                    error_count
);

    localparam int IDX_W = $clog2(FRAME_BYTES + 1);

    localparam logic [1:0] HDR_IDLE = 2'b00;
    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_SOF  = 2'b10;
    localparam logic [1:0] HDR_ILL  = 2'b11;

    // DONE is the one-cycle hand-off slot: the collect buffer is complete and is
    // moved (or dropped) on the next edge, while input is already treated as HUNT.
    typedef enum logic [1:0] {HUNT, COLLECT, DONE} state_t;

    state_t                              state, state_nx;
    logic [IDX_W-1:0]                    idx, idx_nx;
    logic [IDX_W-1:0]                    wr_idx;
    logic                                wr_en;
    logic                                sync_err_nx;
    logic [FRAME_BYTES-1:0][DATA_W-1:0]  buffer;

    logic [1:0]        hdr;
    logic [DATA_W-1:0] data_byte;
    logic              complete, load, drop, err_event;

    assign hdr       = in_word[DATA_W+1:DATA_W];
    assign data_byte = in_word[DATA_W-1:0];
    assign complete  = (state == DONE);
    assign load      = complete && (!frame_valid || frame_ack);
    assign drop      = complete && frame_valid && !frame_ack;
    assign err_event = sync_err_nx || drop;

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        wr_en       = 1'b0;
        wr_idx      = idx;
        sync_err_nx = 1'b0;
        case (state)
            HUNT, DONE: begin
                if (state == DONE) begin
                    state_nx = HUNT;
                    idx_nx   = '0;
                end
                if (in_valid) begin
                    if (hdr == HDR_SOF) begin
                        wr_en    = 1'b1;
                        wr_idx   = '0;
                        idx_nx   = IDX_W'(1);
                        state_nx = COLLECT;
                    end else if (hdr == HDR_ILL) begin
                        sync_err_nx = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    case (hdr)
                        HDR_DATA: begin
                            wr_en  = 1'b1;
                            idx_nx = idx + 1'b1;
                            if (idx == IDX_W'(FRAME_BYTES - 1))
                                state_nx = DONE;
                        end
                        HDR_SOF: begin
                            sync_err_nx = 1'b1;
                            wr_en       = 1'b1;
                            wr_idx      = '0;
                            idx_nx      = IDX_W'(1);
                        end
                        HDR_ILL: begin
                            sync_err_nx = 1'b1;
                            state_nx    = HUNT;
                            idx_nx      = '0;
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                state_nx = HUNT;
                idx_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= HUNT;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buffer <= '0;
        end else begin
            for (int i = 0; i < FRAME_BYTES; i++)
                if (wr_en && wr_idx == IDX_W'(i))
                    buffer[i] <= data_byte;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_data_out <= '0;
            frame_valid    <= 1'b0;
            flow_ctrl_req  <= 1'b0;
            sync_error     <= 1'b0;
            overflow_err   <= 1'b0;
            frame_count    <= '0;
            error_count    <= '0;
        end else begin
            flow_ctrl_req <= frame_valid;
            sync_error    <= sync_err_nx;
            if (load) begin
                frame_data_out <= buffer;
                frame_valid    <= 1'b1;
                frame_count    <= frame_count + 1'b1;
            end else if (frame_ack) begin
                frame_valid <= 1'b0;
            end
            if (drop)
                overflow_err <= 1'b1;
            // a sync error and a drop on the same edge are one error event
            if (err_event && error_count != 8'hFF)
                error_count <= error_count + 1'b1;
        end
    end

endmodule

// File: doc/frame_receiver_with_sync_check.md
Name: frame_receiver_with_sync_check

Overview:
- Downstream stage of frame_generator_with_flow_control.
- Consumes the 10-bit sync-tagged word stream, i.e. a 2-bit sync header plus a data byte.
- Hunts for start-of-frame, collects FRAME_BYTES bytes, and presents the assembled frame in a holding register with a valid/ack handshake.
- Drives a flow-control request back upstream while the holding register is occupied, and reports sync errors and overflow.

Parameters:
FRAME_BYTES, 16, bytes per frame, including the SOF byte
DATA_W, 8, payload bits per word
CNT_W, 16, width of frame_count

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
in_word  in  DATA_W+2  [9:8] sync header, [7:0] byte
in_valid  in  1  in_word valid this cycle
frame_data_out  out  FRAME_BYTES*DATA_W  assembled frame, byte 0 in bits [7:0]
frame_valid  out  1  holding register contains an unacknowledged frame
frame_ack  in  1  consumer accepts frame; effective only when frame_valid=1
flow_ctrl_req  out  1  registered request to upstream to pause; maps onto flow_control_enable
sync_error  out  1  one-cycle pulse on a framing violation
overflow_err  out  1  sticky; set when a completed frame is dropped
frame_count  out  CNT_W  frames delivered into the holding register, wraps
error_count  out  8  sync errors plus dropped frames, saturates at 255

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FSM=HUNT, byte index=0, collect buffer cleared.
- Header decode (evaluated only when in_valid=1):
  - 2'b10 = SOF, i.e. byte 0.
  - 2'b01 = data.
  - 2'b00 = idle.
  - 2'b11 = illegal.
  - When in_valid=0, nothing changes.
- FSM state HUNT:
  - SOF: store byte at index 0, index←1, go to COLLECT.
  - Data or idle: discarded, no error.
  - Illegal: sync_error pulse, stay in HUNT.
- FSM state COLLECT:
  - Data: store at the current index, index+1.
  - Idle: gap, ignored, index unchanged.
  - SOF: sync_error pulse; the partial frame is discarded; the SOF byte becomes byte 0 of the new frame; index←1.
  - Illegal: sync_error pulse; frame discarded; go to HUNT; index←0.
- Frame completion: the data word that makes index reach FRAME_BYTES completes the frame. On the next edge:
  - Holding register empty, or frame_ack=1 this cycle: frame_data_out←frame, frame_valid=1, frame_count+1 (wraps).
  - Holding register full and frame_ack=0: frame dropped, overflow_err←1 (sticky until reset), error_count+1.
  - In all cases the FSM returns to HUNT and index←0.
- Latency: frame_valid rises 1 cycle after the edge on which the last byte is accepted.
- Handshake:
  - frame_ack with frame_valid=1 clears frame_valid on the next edge, unless a new frame loads on the same edge; then frame_valid stays 1 with the new data.
  - frame_ack with frame_valid=0 is ignored.
  - frame_data_out is stable while frame_valid=1.
- flow_ctrl_req: registered copy of the holding-full condition. It is 1 in the cycle after frame_valid becomes 1 and 0 in the cycle after frame_valid clears.
  - Upstream pause is not guaranteed to be immediate, so words arriving while flow_ctrl_req=1 are still processed normally.
- error_count: increments by 1 per sync_error pulse or dropped frame; saturates at 255. A sync error and a drop in the same cycle count as 1 (one event per cycle).
- Reset mid-frame: the partial frame is lost, and frame_valid and the counters clear immediately (asynchronously).

Test Plan:
- Nominal frame: SOF+AA, then data BB,CC,DD,EE,FF,01..09,10 on consecutive cycles.
  - frame_valid=1 one cycle after the 10 byte is accepted.
  - frame_data_out = 0x100908070605040302 01FFEEDDCCBBAA (byte 0 = AA, in the LSB).
  - frame_count=1; flow_ctrl_req=1 one cycle later.
  - frame_ack=1 → frame_valid=0 next cycle, flow_ctrl_req=0 the cycle after.
- Gaps: same frame with idle words (2'b00) and in_valid=0 cycles interleaved → identical frame_data_out, no sync_error.
- Mid-frame SOF: 5 bytes collected, then SOF+55 and 15 further data bytes.
  - One sync_error pulse; error_count=1.
  - Delivered frame byte 0 = 55.
- Illegal header: 2'b11 after 3 bytes → sync_error, FSM back in HUNT; the following data words are ignored until the next SOF.
- Overflow: two complete frames with no ack.
  - The first frame is retained and overflow_err=1; error_count=1; frame_count=1.
  - Ack on the same cycle as the second completion instead → the second frame is loaded, frame_valid stays 1, frame_count=2.
- Reset mid-frame: reset=0 after 8 bytes → all outputs 0 immediately. A full frame after release is received correctly.
